// File: rtl/priority_decoder_seq.sv
// priority_decoder_seq: queues 3-bit codes from a valid/ready port and replays each one as a
// one-hot strobe (HOLD cycles on, GAP cycles off). Define PRIORITY_DECODER_ERR_CNT_EN to add err_cnt.
module priority_decoder_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_code,
    output logic [7:0]             out,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   err,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef PRIORITY_DECODER_ERR_CNT_EN
    ,
    output logic [7:0]             err_cnt
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;

    logic [2:0]      mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CNTW-1:0] count_reg;

    logic            accept;
    logic            push;
    logic            pop;
    logic            illegal;
    logic            fifo_empty;
    logic [2:0]      head_code;
    logic [7:0]      head_onehot;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [7:0]      out_reg, out_next;
    logic            out_valid_reg, out_valid_next;
    logic            err_reg;

    assign in_ready   = !rst && (count_reg < FULL_CNT);
    assign accept     = in_valid && in_ready;
    assign push       = accept && !in_code[3];
    assign illegal    = accept && in_code[3];
    assign fifo_empty = (count_reg == '0);

    // Combinational head read lets the FSM pop and decode in the same cycle.
    assign head_code = mem_reg[rd_ptr_reg];

    // Lines 2 and 3 are swapped relative to the binary code to mirror the encoder.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_decode
            localparam logic [2:0] LINE_CODE = (gi == 2) ? 3'd3 : (gi == 3) ? 3'd2 : 3'(gi);
            assign head_onehot[gi] = (head_code == LINE_CODE);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= in_code[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= illegal;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        pop            = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    out_next       = head_onehot;
                    out_valid_next = 1'b1;
                    cnt_next       = HOLD_LOAD;
                    state_next     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (GAP > 0) begin
                    out_next       = '0;
                    out_valid_next = 1'b0;
                    cnt_next       = GAP_LOAD;
                    state_next     = S_GAP;
                end else if (!fifo_empty) begin
                    // No gap configured: chain the next strobe without a zero cycle.
                    pop            = 1'b1;
                    out_next       = head_onehot;
                    out_valid_next = 1'b1;
                    cnt_next       = HOLD_LOAD;
                end else begin
                    out_next       = '0;
                    out_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (!fifo_empty) begin
                    pop            = 1'b1;
                    out_next       = head_onehot;
                    out_valid_next = 1'b1;
                    cnt_next       = HOLD_LOAD;
                    state_next     = S_HOLD;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                out_next       = '0;
                out_valid_next = 1'b0;
                state_next     = S_IDLE;
            end
        endcase
    end

    assign out        = out_reg;
    assign out_valid  = out_valid_reg;
    assign err        = err_reg;
    assign fifo_count = count_reg;
    assign busy       = (state_reg != S_IDLE) || !fifo_empty;

`ifdef PRIORITY_DECODER_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (illegal && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Directed self-checking bench for priority_decoder_seq: a default instance (HOLD=2, GAP=1)
// and a back-to-back instance (HOLD=1, GAP=0) sharing clock and reset.
module tb_priority_decoder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, busy, err;
    logic [3:0] in_code;
    logic [7:0] out;
    logic [2:0] fifo_count;

    logic       in_valid2, in_ready2, out_valid2, busy2, err2;
    logic [3:0] in_code2;
    logic [7:0] out2;
    logic [2:0] fifo_count2;

`ifdef PRIORITY_DECODER_ERR_CNT_EN
    logic [7:0] err_cnt, err_cnt2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    priority_decoder_seq #(.DEPTH(4), .HOLD(2), .GAP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out(out), .out_valid(out_valid), .busy(busy), .err(err), .fifo_count(fifo_count)
`ifdef PRIORITY_DECODER_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    priority_decoder_seq #(.DEPTH(4), .HOLD(1), .GAP(0)) dut_b2b (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_code(in_code2),
        .out(out2), .out_valid(out_valid2), .busy(busy2), .err(err2), .fifo_count(fifo_count2)
`ifdef PRIORITY_DECODER_ERR_CNT_EN
        , .err_cnt(err_cnt2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_code = 4'h0; in_valid2 = 1'b0; in_code2 = 4'h0;
        repeat (3) tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready2: got %b expected 0", in_ready2); end
        n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL rst_out: got %h expected 00", out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
        tick();
        n_checks++; if (out !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_out: got %h/%b expected 00/0", out, out_valid); end
        n_checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL post_rst_idle: got busy %b count %0d expected 0/0", busy, fifo_count); end
`ifdef PRIORITY_DECODER_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
`endif
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [7:0] exp_out [5];
        logic       exp_busy [5];
        exp_out  = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h00};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        in_valid = 1'b1; in_code = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) begin
                in_valid = 1'b0;
                n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
            end
            n_checks++; if (out !== exp_out[c]) begin n_fail++; $display("FAIL single_out[%0d]: got %h expected %h", c, out, exp_out[c]); end
            n_checks++; if (out_valid !== (exp_out[c] != 8'h00)) begin n_fail++; $display("FAIL single_valid[%0d]: got %b expected %b", c, out_valid, exp_out[c] != 8'h00); end
            n_checks++; if (busy !== exp_busy[c]) begin n_fail++; $display("FAIL single_busy[%0d]: got %b expected %b", c, busy, exp_busy[c]); end
        end
        $display("test_single done");
    endtask

    task automatic test_burst();
        logic [2:0] codes [4];
        logic [7:0] exp_out [14];
        int         peak = 0;
        codes   = '{3'd0, 3'd1, 3'd3, 3'd7};
        exp_out = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h00,
                    8'h04, 8'h04, 8'h00, 8'h80, 8'h80, 8'h00, 8'h00};
        for (int c = 0; c < 14; c++) begin
            if (c < 4) begin
                in_valid = 1'b1; in_code = {1'b0, codes[c]};
            end else begin
                in_valid = 1'b0;
            end
            tick();
            n_checks++; if (out !== exp_out[c]) begin n_fail++; $display("FAIL burst_out[%0d]: got %h expected %h", c, out, exp_out[c]); end
            n_checks++; if (out_valid !== (exp_out[c] != 8'h00)) begin n_fail++; $display("FAIL burst_valid[%0d]: got %b expected %b", c, out_valid, exp_out[c] != 8'h00); end
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        n_checks++; if (peak != 3) begin n_fail++; $display("FAIL burst_peak: got %0d expected 3", peak); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: got %b expected 0", busy); end
        $display("test_burst done");
    endtask

    task automatic test_full();
        logic exp_rdy [10];
        int   transfers = 0;
        int   strobes = 0;
        int   peak = 0;
        int   guard = 0;
        logic prev_ov;
        exp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        prev_ov  = out_valid;
        in_valid = 1'b1; in_code = 4'd5;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (in_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL full_ready[%0d]: got %b expected %b", c, in_ready, exp_rdy[c]); end
            if (in_ready) transfers++;
            tick();
            if (out_valid && !prev_ov) strobes++;
            if (out_valid) begin
                n_checks++; if (out !== 8'h20) begin n_fail++; $display("FAIL full_out: got %h expected 20", out); end
            end
            prev_ov = out_valid;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        in_valid = 1'b0;
        while (busy && guard < 60) begin
            tick();
            if (out_valid && !prev_ov) strobes++;
            if (out_valid) begin
                n_checks++; if (out !== 8'h20) begin n_fail++; $display("FAIL full_drain_out: got %h expected 20", out); end
            end
            prev_ov = out_valid;
            guard++;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_drain_timeout: got busy %b expected 0", busy); end
        n_checks++; if (transfers != 7) begin n_fail++; $display("FAIL full_transfers: got %0d expected 7", transfers); end
        n_checks++; if (strobes != 7) begin n_fail++; $display("FAIL full_strobes: got %0d expected 7", strobes); end
        n_checks++; if (peak != 4) begin n_fail++; $display("FAIL full_peak: got %0d expected 4", peak); end
        $display("test_full done");
    endtask

    task automatic test_illegal();
        logic [3:0] codes [3];
        logic [7:0] got [4];
        int         n_got = 0;
        int         err_cycles = 0;
        logic       prev_ov;
        codes   = '{4'b0100, 4'b1101, 4'b0110};
        prev_ov = out_valid;
        for (int c = 0; c < 12; c++) begin
            if (c < 3) begin
                in_valid = 1'b1; in_code = codes[c];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            n_checks++; if (err !== (c == 1)) begin n_fail++; $display("FAIL illegal_err[%0d]: got %b expected %b", c, err, c == 1); end
            if (err) err_cycles++;
            if (out_valid && !prev_ov && n_got < 4) begin
                got[n_got] = out;
                n_got++;
            end
            prev_ov = out_valid;
        end
        n_checks++; if (err_cycles != 1) begin n_fail++; $display("FAIL illegal_err_width: got %0d expected 1", err_cycles); end
        n_checks++; if (n_got != 2) begin n_fail++; $display("FAIL illegal_strobe_count: got %0d expected 2", n_got); end
        if (n_got >= 2) begin
            n_checks++; if (got[0] !== 8'h10) begin n_fail++; $display("FAIL illegal_first: got %h expected 10", got[0]); end
            n_checks++; if (got[1] !== 8'h40) begin n_fail++; $display("FAIL illegal_second: got %h expected 40", got[1]); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL illegal_busy_end: got %b expected 0", busy); end
`ifdef PRIORITY_DECODER_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL illegal_err_cnt: got %0d expected 1", err_cnt); end
`endif
        $display("test_illegal done");
    endtask

    task automatic test_reset_mid();
        logic [2:0] codes [5];
        codes = '{3'd1, 3'd6, 3'd3, 3'd4, 3'd5};
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_code = {1'b0, codes[c]};
            tick();
        end
        n_checks++; if (out !== 8'h40 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_out: got %h/%b expected 40/1", out, out_valid); end
        n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 3", fifo_count); end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        n_checks++; if (out !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got %h/%b expected 00/0", out, out_valid); end
        n_checks++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got count %0d busy %b expected 0/0", fifo_count, busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b expected 1", in_ready); end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++; if (out !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_replay[%0d]: got out %h busy %b expected 00/0", c, out, busy); end
        end
`ifdef PRIORITY_DECODER_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_err_cnt: got %0d expected 0", err_cnt); end
`endif
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes [2];
        logic [7:0] exp_out [5];
        codes   = '{4'd2, 4'd3};
        exp_out = '{8'h00, 8'h08, 8'h04, 8'h00, 8'h00};
        for (int c = 0; c < 5; c++) begin
            if (c < 2) begin
                in_valid2 = 1'b1; in_code2 = codes[c];
            end else begin
                in_valid2 = 1'b0;
            end
            tick();
            n_checks++; if (out2 !== exp_out[c]) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h expected %h", c, out2, exp_out[c]); end
            n_checks++; if (out_valid2 !== (exp_out[c] != 8'h00)) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", c, out_valid2, exp_out[c] != 8'h00); end
        end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", busy2); end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
